tx_rs232: RTL and testbench
===========================

// Module: tx_rs232
// PURPOSE
//  UART transmitter. Serialises bytes as 11-bit frames: start(0), D0..D7 LSB first,
//  parity bit, stop(1). Each bit lasts CLK_PER_BIT cycles.
//  Sits on the FPGA TX pin and drains a small byte FIFO fed by the pattern-match
//  core over a valid/ready handshake.
// PARAMETERS
//  CLK_PER_BIT  104  clk_s cycles per serial bit (>=2)
//  PARITY_ODD   0    0: even parity bit = ^data; 1: odd parity bit = ~^data
//  FIFO_DEPTH   4    byte buffer entries (power of 2, >=2)
// PORTS
//  clk_s    in   1  system clock; single clock domain
//  rst_s    in   1  synchronous reset, active-high
//  iDATA    in   8  byte to send
//  iVALID   in   1  iDATA valid; write occurs on the edge where iVALID & oREADY
//  oREADY   out  1  FIFO not full
//  oTX      out  1  serial line, registered, idle high
//  oBUSY    out  1  frame in progress or FIFO non-empty
//  oDONE    out  1  one-cycle pulse: last cycle of a frame's stop bit
// BEHAVIOUR
//  Reset: oTX=1, oREADY=1 on the cycle after reset, oBUSY=0, oDONE=0; FIFO emptied;
//   FSM=IDLE; counters=0. Reset mid-frame aborts: oTX=1 from the next edge, byte lost.
//  FIFO: write when iVALID&oREADY; read only by the FSM on frame load.
//   Full: oREADY=0 and writes ignored. Empty: FSM stays IDLE.
//   Write and read on the same edge when full: the read frees a slot, but oREADY is
//   computed from registered count, so the write is refused that cycle.
//   Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE -> START when FIFO non-empty. Pop the byte into an 8-bit shift reg, latch the
//    parity bit, and drive oTX=0 on the same edge.
//   Baud counter runs 0..CLK_PER_BIT-1. A state advances on the edge where it equals
//    CLK_PER_BIT-1; the counter then returns to 0.
//   START -> DATA: oTX=D0.
//   DATA: shift right on each bit boundary. After 8 bits -> PARITY (bit counter 0..7).
//   PARITY -> STOP: oTX=1.
//   STOP at last cycle: oDONE=1. If FIFO non-empty, pop and go straight to START
//    (no idle gap). Otherwise go to IDLE.
//  Latency: a write at edge k into an empty, idle block gives oTX low from edge k+1
//   (FSM sees the registered count). Frame length is exactly 11*CLK_PER_BIT cycles.
//  oBUSY = (state!=IDLE) | (count!=0).
//  iDATA/iVALID may change at any time; only the write edge matters.
// STRUCTURE
//  Shared package uart_pkg: state enum, FRAME_BITS=11, DATA_BITS=8, parity helper
//   function. rx and tx share CLK_PER_BIT default 104.
//  Sub-module tx_fifo (sync FIFO: wr/rd, full/empty, count).
//  Top holds the FSM, baud counter, bit counter and shift reg.
// TESTING
//  1. Idle, PARITY_ODD=0, write 0x55. Sample oTX mid-bit: 0,1,0,1,0,1,0,1,0,0,1.
//     oDONE pulses once, 1144 cycles after oTX falls minus 1.
//  2. PARITY_ODD=1, write 0x00. Parity bit=1. With 0xFF the parity bit=1.
//     With PARITY_ODD=0 and 0xFF the parity bit=0.
//  3. Write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles while idle.
//     First byte is popped at once, so all 5 are accepted. A 6th write while 4 are
//     queued sees oREADY=0 and is dropped. Frames are contiguous (stop bit followed
//     directly by start). 5 oDONE pulses, then oBUSY=0.
//  4. Assert rst_s during DATA bit 3 of 0xA5. oTX=1 the next cycle, oBUSY=0, no oDONE.
//     A new write of 0x3C afterwards sends a clean frame.
//  5. Hold iVALID=1 with oREADY=0 (full). iDATA changes are ignored until oREADY
//     rises; the accepted byte is the value on the accepting edge.
//  6. CLK_PER_BIT=2 corner: back-to-back 0x80,0x7F. Bit timing is exact and the
//     frames total 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, the transmitter state encoding,
// the default baud divider, and the parity helper.
package uart_pkg;

    localparam int unsigned FRAME_BITS          = 11;
    localparam int unsigned DATA_BITS           = 8;
    localparam int unsigned CLK_PER_BIT_DEFAULT = 104;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Even parity: bit = ^data (XOR of the data bits, so the data bits plus
    // the parity bit hold an even number of ones). Odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO between the valid/ready write side and the
// transmitter FSM.
// Ports:
//   clk_s, rst_s  clock, synchronous active-high reset (empties the FIFO)
//   wr, wdata     write request/data; ignored while full
//   rd, rdata     read request/head-of-queue data; ignored while empty
//   full, empty   occupancy flags from the registered count
//   count         number of stored entries (0..DEPTH)
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_s,
    input  logic                     rst_s,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;
    assign rdata = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_s) begin
        if (do_wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/tx_rs232.sv
// UART transmitter: drains a small byte FIFO and serialises each byte as an
// 11-bit frame (start 0, D0..D7 LSB first, parity, stop 1), each bit held for
// CLK_PER_BIT clocks. Frames run back to back while the FIFO has data.
// Ports:
//   clk_s   system clock
//   rst_s   synchronous active-high reset; aborts any frame in progress
//   iDATA   byte to send, written when iVALID & oREADY on a clock edge
//   iVALID  iDATA valid
//   oREADY  FIFO not full
//   oTX     registered serial line, idle high
//   oBUSY   frame in progress or FIFO non-empty
//   oDONE   one-cycle pulse on the last cycle of a stop bit
module tx_rs232
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk_s,
    input  logic       rst_s,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oTX,
    output logic       oBUSY,
    output logic       oDONE
);

    localparam int unsigned BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t                    state_q;
    tx_state_t                    state_d;
    logic [BW-1:0]                baud_q;
    logic [2:0]                   bit_q;
    logic [DATA_BITS-1:0]         shreg_q;
    logic                         par_q;
    logic                         tx_q;
    logic                         pop;
    logic                         bit_end;
    logic                         done;

    logic [DATA_BITS-1:0]         fifo_rdata;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_s (clk_s),
        .rst_s (rst_s),
        .wr    (iVALID),
        .wdata (iDATA),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_q == BAUD_LAST);
    assign oREADY  = ~fifo_full;
    assign oTX     = tx_q;
    assign oBUSY   = (state_q != ST_IDLE) | (fifo_count != '0);
    assign oDONE   = done;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_q == BIT_LAST) state_d = ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    // Chain straight into the next frame with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (pop) begin
                // Frame load: the start bit goes out on this same edge.
                shreg_q <= fifo_rdata;
                par_q   <= parity_bit(fifo_rdata, PARITY_ODD != 0);
                tx_q    <= 1'b0;
                baud_q  <= '0;
                bit_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        baud_q <= '0;
                        tx_q   <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            baud_q <= '0;
                            tx_q   <= shreg_q[0];
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            baud_q  <= '0;
                            shreg_q <= shreg_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                            // shreg_q[1] is the next data bit before the shift lands.
                            tx_q    <= (bit_q == BIT_LAST) ? par_q : shreg_q[1];
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    ST_PARITY, ST_STOP: begin
                        if (bit_end) begin
                            baud_q <= '0;
                            tx_q   <= 1'b1;
                        end else begin
                            baud_q <= baud_q + 1'b1;
                        end
                    end
                    default: begin
                        baud_q <= '0;
                        tx_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_rs232.sv
// Bench for tx_rs232: three instances (CLK_PER_BIT 104/even, 4/odd, 2/even).
// The stimulus side records each accepted byte in a per-instance expected
// queue; a monitor decodes the serial line mid-bit and compares each frame
// and its oDONE timing against a frame built from the byte with plain
// arithmetic.
module tb_tx_rs232;

    localparam int unsigned CPB0 = 104;
    localparam int unsigned CPB1 = 4;
    localparam int unsigned CPB2 = 2;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] data [3];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;

    logic [7:0]  expmem [3][256];
    int unsigned wr_i [3];
    int unsigned rd_i [3];
    int unsigned done_cnt [3];
    int unsigned done_at [3][16];
    bit          in_frame [3];
    int unsigned t_in [3];
    logic [10:0] bits [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_rs232 #(.CLK_PER_BIT(CPB0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut0 (
        .clk_s(clk), .rst_s(rst[0]), .iDATA(data[0]), .iVALID(valid[0]),
        .oREADY(ready[0]), .oTX(tx[0]), .oBUSY(busy[0]), .oDONE(done[0]));
    tx_rs232 #(.CLK_PER_BIT(CPB1), .PARITY_ODD(1), .FIFO_DEPTH(4)) dut1 (
        .clk_s(clk), .rst_s(rst[1]), .iDATA(data[1]), .iVALID(valid[1]),
        .oREADY(ready[1]), .oTX(tx[1]), .oBUSY(busy[1]), .oDONE(done[1]));
    tx_rs232 #(.CLK_PER_BIT(CPB2), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut2 (
        .clk_s(clk), .rst_s(rst[2]), .iDATA(data[2]), .iVALID(valid[2]),
        .oREADY(ready[2]), .oTX(tx[2]), .oBUSY(busy[2]), .oDONE(done[2]));

    function automatic int unsigned cpb(input int d);
        case (d)
            0:       return CPB0;
            1:       return CPB1;
            default: return CPB2;
        endcase
    endfunction

    // Reference frame, bit index 0 = start bit, sent first.
    function automatic logic [10:0] frame_of(input int d, input logic [7:0] b);
        int unsigned ones;
        logic        p;
        ones = $countones(b);
        p = (ones % 2 == 1);
        if (d == 1) p = ~p;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic check(input int d, input string name,
                         input int unsigned got, input int unsigned want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     d, name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input int d, input string name);
        vectors++;
        miscompares++;
        $display("FAIL dut%0d %s at cycle %0d", d, name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [7:0] b);
        expmem[d][wr_i[d] % 256] = b;
        wr_i[d]++;
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit expect_out);
        int unsigned n;
        n = 0;
        data[d]  = b;
        valid[d] = 1'b1;
        while (!ready[d] && n < 5000) begin
            tick();
            n++;
        end
        if (!ready[d]) begin
            fail_now(d, "send_ready_timeout");
        end else begin
            tick();
            if (expect_out) push(d, b);
        end
        valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((busy[d] || rd_i[d] != wr_i[d]) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail_now(d, "drain_timeout");
        check(d, "drain_busy", busy[d], 0);
        check(d, "drain_frames_seen", rd_i[d], wr_i[d]);
    endtask

    task automatic monitor();
        int unsigned c;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                c = cpb(d);
                if (rst[d]) begin
                    in_frame[d] = 1'b0;
                end else begin
                    if (!in_frame[d] && tx[d] == 1'b0) begin
                        in_frame[d] = 1'b1;
                        t_in[d]     = 0;
                        bits[d]     = '1;
                    end else if (in_frame[d]) begin
                        t_in[d]++;
                    end
                    if (in_frame[d]) begin
                        if (t_in[d] % c == c / 2) bits[d][t_in[d] / c] = tx[d];
                        if (t_in[d] == 11 * c - 1) begin
                            check(d, "done_on_last_stop_cycle", done[d], 1);
                            if (rd_i[d] == wr_i[d]) begin
                                fail_now(d, "unexpected_frame");
                            end else begin
                                check(d, "frame", bits[d],
                                      frame_of(d, expmem[d][rd_i[d] % 256]));
                                rd_i[d]++;
                            end
                            done_at[d][done_cnt[d] % 16] = cyc;
                            done_cnt[d]++;
                            in_frame[d] = 1'b0;
                        end else if (done[d]) begin
                            fail_now(d, "done_early");
                        end
                    end else if (done[d]) begin
                        fail_now(d, "done_outside_frame");
                    end
                end
            end
        end
    endtask

    task automatic run_tests();
        int unsigned dc;
        int unsigned n;
        int unsigned k;
        bit          accepted;
        logic [7:0]  b;

        // Single 0x55 frame, start bit one edge after the write.
        dc = done_cnt[0];
        send(0, 8'h55, 1);
        tick();
        check(0, "start_latency", tx[0], 0);
        wait_idle(0, 2000);
        check(0, "single_done_count", done_cnt[0] - dc, 1);

        // Parity corners.
        send(1, 8'h00, 1);
        send(1, 8'hFF, 1);
        wait_idle(1, 300);
        send(0, 8'hFF, 1);
        wait_idle(0, 2000);

        // Five consecutive writes fill the FIFO behind the first popped byte.
        dc = done_cnt[0];
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1);
        check(0, "ready_low_when_full", ready[0], 0);
        data[0]  = 8'h06;
        valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check(0, "ready_low_while_held", ready[0], 0);
            tick();
        end
        valid[0] = 1'b0;
        wait_idle(0, 8000);
        check(0, "burst_done_count", done_cnt[0] - dc, 5);
        for (int i = 1; i < 5; i++)
            check(0, "burst_contiguous",
                  done_at[0][(dc + i) % 16] - done_at[0][(dc + i - 1) % 16], 11 * CPB0);

        // Reset in the middle of data bit 3 of 0xA5 loses the byte.
        dc = done_cnt[0];
        send(0, 8'hA5, 0);
        n = 0;
        while (tx[0] && n < 100) begin
            tick();
            n++;
        end
        if (tx[0]) fail_now(0, "abort_frame_never_started");
        repeat (4 * CPB0 + CPB0 / 2) tick();
        rst[0] = 1'b1;
        tick();
        check(0, "abort_tx_high", tx[0], 1);
        check(0, "abort_busy_low", busy[0], 0);
        check(0, "abort_done_low", done[0], 0);
        rst[0] = 1'b0;
        tick();
        check(0, "abort_ready_high", ready[0], 1);
        check(0, "abort_no_done", done_cnt[0] - dc, 0);
        send(0, 8'h3C, 1);
        wait_idle(0, 2000);

        // Held iVALID while full: only the value on the accepting edge counts.
        for (int i = 0; i < 5; i++) send(1, 8'($urandom), 1);
        check(1, "hold_ready_low", ready[1], 0);
        valid[1] = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 500) begin
            b       = 8'($urandom);
            data[1] = b;
            if (ready[1]) begin
                tick();
                push(1, b);
                accepted = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        valid[1] = 1'b0;
        if (!accepted) fail_now(1, "hold_never_accepted");
        wait_idle(1, 1000);

        // Minimum divider, back-to-back frames.
        dc = done_cnt[2];
        send(2, 8'h80, 1);
        k = cyc;
        send(2, 8'h7F, 1);
        wait_idle(2, 200);
        check(2, "cpb2_done_count", done_cnt[2] - dc, 2);
        check(2, "cpb2_contiguous", done_at[2][(dc + 1) % 16] - done_at[2][dc % 16], 22);
        check(2, "cpb2_total_cycles", done_at[2][(dc + 1) % 16] - k, 44);

        // Random traffic with random gaps.
        for (int d = 0; d < 3; d++) begin
            n = (d == 0) ? 5 : 25;
            for (int i = 0; i < int'(n); i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3 * cpb(d))) tick();
                send(d, 8'($urandom), 1);
            end
            wait_idle(d, (n + 2) * 22 * cpb(d));
        end
    endtask

    initial begin
        rst   = '1;
        valid = '0;
        for (int d = 0; d < 3; d++) begin
            data[d]     = '0;
            wr_i[d]     = 0;
            rd_i[d]     = 0;
            done_cnt[d] = 0;
            in_frame[d] = 1'b0;
            t_in[d]     = 0;
            bits[d]     = '1;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check(d, "reset_tx", tx[d], 1);
            check(d, "reset_busy", busy[d], 0);
            check(d, "reset_done", done[d], 0);
            check(d, "reset_ready", ready[d], 1);
        end
        rst = '0;
        tick();
        fork
            monitor();
            run_tests();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
